// File: rtl/jk_pkg.sv
// Shared definitions for JK flip-flop based sequential blocks.
//   jk_mode_e  - J/K excitation encoding ({j,k}): hold, reset, set, toggle
//   jk_next    - next-state function of a single JK flip-flop
//   params_ok  - elaboration-time range check for counter WIDTH/MODULUS
package jk_pkg;

  // Legal parameter ranges for JK based counters.
  localparam int unsigned WIDTH_MIN   = 2;
  localparam int unsigned WIDTH_MAX   = 16;
  localparam int unsigned MODULUS_MIN = 2;

  // Excitation encoding, packed as {j, k}.
  typedef enum logic [1:0] {
    HOLD   = 2'b00,
    RESET  = 2'b01,
    SET    = 2'b10,
    TOGGLE = 2'b11
  } jk_mode_e;

  // Standard JK characteristic: 00 hold, 01 reset, 10 set, 11 toggle.
  function automatic logic jk_next(input logic q, input logic j, input logic k);
    jk_mode_e mode;
    logic     nxt;
    mode = jk_mode_e'({j, k});
    case (mode)
      HOLD:    nxt = q;
      RESET:   nxt = 1'b0;
      SET:     nxt = 1'b1;
      default: nxt = ~q;
    endcase
    return nxt;
  endfunction

  // True when WIDTH is in 2..16 and MODULUS is in 2..2**WIDTH.
  function automatic bit params_ok(input int unsigned width, input int unsigned modulus);
    longint unsigned span;
    span = 64'd1 << width;
    return (width >= WIDTH_MIN) && (width <= WIDTH_MAX) &&
           (modulus >= MODULUS_MIN) && (64'(modulus) <= span);
  endfunction

endpackage

// File: rtl/jk_ff_cell.sv
// Single behavioural JK flip-flop.
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset, clears q
//   j, k  - excitation inputs (00 hold, 01 reset, 10 set, 11 toggle)
//   q     - flop state
module jk_ff_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  // State register with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= 1'b0;
    end else begin
      q <= jk_next(q, j, k);
    end
  end

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-MODULUS up/down counter built from a bank of JK flip-flops.
// The excitation logic computes J/K per bit every cycle so one flop bank
// covers hold (J=K=0), counting (toggle only changing bits) and parallel
// load (set/reset on every bit).
//   clk      - rising-edge clock
//   reset    - asynchronous active-high reset
//   en       - count enable
//   up       - direction, 1 = increment, 0 = decrement
//   load     - synchronous parallel load, priority over en
//   din      - load value, clamped to MODULUS-1 when out of range
//   q        - counter state (JK flop outputs)
//   j_bus    - J inputs applied this cycle (combinational)
//   k_bus    - K inputs applied this cycle (combinational)
//   tc       - terminal count (combinational), high on the wrap step
//   wrap     - registered one-cycle pulse after a wrap step
//   load_err - registered one-cycle pulse after an out-of-range load
module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j_bus,
  output logic [WIDTH-1:0] k_bus,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  // One extra bit so q+1 at the all-ones value and MODULUS=2**WIDTH
  // are representable without aliasing.
  localparam int unsigned        AW      = WIDTH + 1;
  localparam logic [AW-1:0]      TOP_EXT = AW'(MODULUS - 1);
  localparam logic [AW-1:0]      MOD_EXT = AW'(MODULUS);
  localparam logic [WIDTH-1:0]   TOP     = WIDTH'(MODULUS - 1);

  // Reject illegal parameterisations at elaboration.
  if (!params_ok(WIDTH, MODULUS)) begin : g_param_err
    $error("jk_mod_counter: WIDTH=%0d MODULUS=%0d out of range", WIDTH, MODULUS);
  end

  logic [AW-1:0]    q_ext;
  logic [AW-1:0]    din_ext;
  logic             at_top;
  logic             at_zero;
  logic [WIDTH-1:0] inc_val;
  logic [WIDTH-1:0] dec_val;
  logic [WIDTH-1:0] count_next;
  logic             load_oor;
  logic [WIDTH-1:0] load_val;

  assign q_ext   = {1'b0, q};
  assign din_ext = {1'b0, din};
  assign at_top  = (q_ext == TOP_EXT);
  assign at_zero = (q_ext == '0);

  // Next count value with wrap at both ends of the range.
  assign inc_val    = at_top  ? '0  : WIDTH'(q_ext + AW'(1));
  assign dec_val    = at_zero ? TOP : WIDTH'(q_ext - AW'(1));
  assign count_next = up ? inc_val : dec_val;

  // Load value clamped into range.
  assign load_oor = (din_ext >= MOD_EXT);
  assign load_val = load_oor ? TOP : din;

  // Excitation: load sets/resets every bit, count toggles changing bits.
  always_comb begin
    j_bus = '0;
    k_bus = '0;
    if (load) begin
      j_bus = load_val;
      k_bus = ~load_val;
    end else if (en) begin
      j_bus = count_next ^ q;
      k_bus = count_next ^ q;
    end
  end

  // Terminal count coincides exactly with a wrapping count step.
  assign tc = en & ~load & (up ? at_top : at_zero);

  // Flop bank.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_ff_cell u_ff (
      .clk   (clk),
      .reset (reset),
      .j     (j_bus[i]),
      .k     (k_bus[i]),
      .q     (q[i])
    );
  end

  // Status pulses, one cycle after the causing edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= tc;
      load_err <= load & load_oor;
    end
  end

endmodule

// File: tb/tb_jk_mod_counter.sv
// Self-checking bench for jk_mod_counter (WIDTH=4, MODULUS=10).
module tb_jk_mod_counter;

  localparam int W = 4;
  localparam int M = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] din;
  logic [W-1:0] q;
  logic [W-1:0] j_bus;
  logic [W-1:0] k_bus;
  logic         tc;
  logic         wrap;
  logic         load_err;

  typedef struct packed {
    logic [W-1:0] q;
    logic         wrap;
    logic         load_err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   m_q    = 0;

  jk_mod_counter #(.WIDTH(W), .MODULUS(M)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .load     (load),
    .din      (din),
    .q        (q),
    .j_bus    (j_bus),
    .k_bus    (k_bus),
    .tc       (tc),
    .wrap     (wrap),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, check combinational outputs, then check
  // the registered outcome against the scoreboard after the edge.
  task automatic step(input logic e, input logic u, input logic l, input logic [W-1:0] d,
                      input bit chk_lit, input logic [W-1:0] lit_j, input logic [W-1:0] lit_k);
    int   nxt;
    int   val;
    bit   oor;
    bit   m_tc;
    logic [W-1:0] mj;
    logic [W-1:0] mk;
    exp_t ex;
    @(negedge clk);
    en = e; up = u; load = l; din = d;
    #1;
    oor = (int'(d) >= M);
    val = oor ? M - 1 : int'(d);
    if (u) nxt = (m_q == M - 1) ? 0 : m_q + 1;
    else   nxt = (m_q == 0) ? M - 1 : m_q - 1;
    m_tc = e && !l && (u ? (m_q == M - 1) : (m_q == 0));
    if (l) begin
      mj = W'(val); mk = ~W'(val);
      nxt = val;
    end else if (e) begin
      mj = W'(nxt) ^ W'(m_q); mk = mj;
    end else begin
      mj = '0; mk = '0;
      nxt = m_q;
    end
    check("tc", 32'(tc), 32'(m_tc));
    check("j_bus", 32'(j_bus), 32'(mj));
    check("k_bus", 32'(k_bus), 32'(mk));
    if (chk_lit) begin
      check("j_lit", 32'(j_bus), 32'(lit_j));
      check("k_lit", 32'(k_bus), 32'(lit_k));
    end
    sb.push_back('{q: W'(nxt), wrap: m_tc, load_err: l && oor});
    m_q = nxt;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      ex = sb.pop_front();
      check("q", 32'(q), 32'(ex.q));
      check("wrap", 32'(wrap), 32'(ex.wrap));
      check("load_err", 32'(load_err), 32'(ex.load_err));
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; din = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_q", 32'(q), 32'd0);
    check("rst_wrap", 32'(wrap), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    check("rst_tc", 32'(tc), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    m_q = 0;

    // Up count through the 9->0 wrap.
    for (int i = 0; i < 12; i++)
      step(1'b1, 1'b1, 1'b0, '0, (i == 9), 4'b1001, 4'b1001);

    // Down wrap from 0, then the 8->7 step toggles all bits.
    step(1'b0, 1'b0, 1'b1, 4'd0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b1, 4'b1111, 4'b1111);

    // Loads: in range, out of range, boundaries, load beating en at top.
    step(1'b0, 1'b1, 1'b1, 4'd6, 1'b1, 4'b0110, 4'b1001);
    step(1'b0, 1'b1, 1'b1, 4'd13, 1'b1, 4'b1001, 4'b0110);
    step(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, '0);
    step(1'b0, 1'b1, 1'b1, 4'd10, 1'b0, '0, '0);
    step(1'b0, 1'b1, 1'b1, 4'd15, 1'b0, '0, '0);
    step(1'b0, 1'b1, 1'b1, 4'd9, 1'b0, '0, '0);
    step(1'b1, 1'b1, 1'b1, 4'd3, 1'b0, '0, '0);

    // Hold for three cycles.
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'b0, '0, 1'b1, 4'b0000, 4'b0000);

    // Direction flip every cycle from 5.
    step(1'b0, 1'b1, 1'b1, 4'd5, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++)
      step(1'b1, (i % 2 == 0), 1'b0, '0, 1'b0, '0, '0);

    // Count to 7, then asynchronous reset between edges.
    step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, '0);
    step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, '0);
    check("pre_rst_q", 32'(q), 32'd7);
    en = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_q", 32'(q), 32'd0);
    check("async_rst_wrap", 32'(wrap), 32'd0);
    check("async_rst_load_err", 32'(load_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    m_q = 0;
    step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, '0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
